control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit directly upstream of the CPU data path: steps T0..T7 per instruction and drives
//  every register in/out strobe, ALU op, memory Read/Write and IR load. Decodes IR (held in data path, fed back
//  as ir) into one-hot R0..R15 select vectors. Handshakes with memory via mem_ready; halts on halt opcode/fault.
// PARAMETERS
//  NREG        16   general registers R0..R15 (select vector width)
//  OP_W        5    opcode width, ir[31:27]
//  MEM_WAIT    255  max cycles waiting for mem_ready before mem_fault
// PORTS
//  clock      in  1   rising-edge clock
//  clear      in  1   async active-high reset
//  ir         in  32  IR contents: op[31:27] ra[26:23] rb[22:19] rc[18:15] c[18:0]
//  mem_ready  in  1   memory completed current Read/Write this cycle
//  r_out      out 16  one-hot GPR bus-drive select (Rnout)
//  r_in       out 16  one-hot GPR load enable (Rnin)
//  PCout,PCin,IncPC,MARin,MDRin,MDRout,IRin,Yin,Zlowin,Zhighin,Zlowout,Zhighout,HIin,HIout,LOin,LOout,Cout
//             out 1 each  data-path strobes
//  Read,Write out 1   memory request, held until mem_ready
//  alu_op     out 5   ALU function code (= opcode for ALU classes; ADD=00011 for address calc/IncPC)
//  run        out 1   1 while executing; 0 in HALTED
//  illegal_op out 1   one-cycle pulse on unknown opcode (in T3)
//  mem_fault  out 1   sticky; set on MEM_WAIT expiry
// BEHAVIOUR
//  Clear (any time, async): state<=T0, wait_cnt<=0, mem_fault<=0, run<=1 on first clock after release;
//   during clear all outputs 0. Strobes are combinational from state+ir; only state/counters registered.
//  Fetch: T0 PCout,MARin,IncPC,Zlowin -> T1 Zlowout,PCin -> T1W Read held; MDRin only in cycle mem_ready=1,
//   then ->T2 -> T2 MDRout,IRin -> T3. IR valid from T3.
//  Classes (op decode in T3..T7; last step returns to T0):
//   ALU R (add,sub,and,or,shr,shl,ror,rol,00000-00111 excl. none): T3 r_out[rb],Yin; T4 r_out[rc],alu_op,Zlowin;
//    T5 Zlowout,r_in[ra].
//   ALU imm (addi,andi,ori 01000-01010): as R but T4 Cout instead of r_out[rc]; alu_op mapped to add/and/or.
//   ld 01011: T3 r_out[rb](none if rb==0, bus reads 0),Yin; T4 Cout,ADD,Zlowin; T5 Zlowout,MARin;
//    T6 Read held until mem_ready, MDRin on that cycle; T7 MDRout,r_in[ra].
//   st 01100: T3-T5 as ld; T6 r_out[ra],MDRin; T7 Write held until mem_ready.
//   mul 01101/div 01110: T3 r_out[ra],Yin; T4 r_out[rb],alu_op,Zlowin,Zhighin; T5 Zlowout,LOin; T6 Zhighout,HIin.
//   mfhi 01111/mflo 10000: T3 HIout|LOout, r_in[ra].  nop 10001: T3 no strobes.
//   halt 10010: -> HALTED; run=0, all strobes 0 until clear.
//   other: illegal_op pulse in T3, treated as nop.
//  Memory wait: wait_cnt counts cycles in any wait state with mem_ready=0, zeroed on exit. On reaching MEM_WAIT:
//   mem_fault<=1, drop Read/Write, -> HALTED. mem_ready in non-wait states ignored.
//  Invariants: <=1 bus driver per cycle; r_in/r_out at most one-hot; R0 selectable for r_in (ld/ALU dest);
//   PC increments exactly once per instruction (T0/T1) so a mid-sequence clear restarts fetch at current PC value.
// TESTING
//  Clear asserted mid-T4 of add -> outputs 0 immediately, after release T0 strobes PCout,MARin,IncPC,Zlowin.
//  ir=add R3,R1,R2, mem_ready=1 at T1W -> T3 r_out=0x0002,Yin; T4 r_out=0x0004,alu_op=00011; T5 r_in=0x0008; 7 cycles.
//  ld R2,0x55(R0), mem_ready delayed 3 cycles at T6 -> Read high 4 cycles, MDRin only last, T7 r_in=0x0004.
//  st R4,0(R5) -> T6 r_out=0x0010,MDRin; T7 Write held until mem_ready, then T0.
//  mem_ready never asserted in T1W, MEM_WAIT=4 -> mem_fault=1 after 4 cycles, run=0, Read=0, stays until clear.
//  ir opcode 11111 -> illegal_op one pulse in T3, no r_in, next fetch; halt -> run=0 held 20 cycles.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the CPU data path.
// Steps each instruction through fetch (T0, T1, T1W, T2) and execute (T3..T7).
// It drives every data-path strobe, the ALU function code and the memory handshake.
// Ports:
//   clock, clear        rising-edge clock; asynchronous active-high reset
//   ir                  IR contents fed back from the data path (op/ra/rb/rc/c)
//   mem_ready           memory finished the pending Read/Write this cycle
//   r_out, r_in         one-hot GPR bus-drive select / load enable
//   PCout .. Cout       single-bit data-path strobes
//   Read, Write         memory request, held until mem_ready
//   alu_op              ALU function code
//   run                 high while executing, low once halted
//   illegal_op          one-cycle pulse on an unknown opcode
//   mem_fault           sticky; memory did not answer within MEM_WAIT cycles
module control_sequencer #(
   parameter int unsigned NREG     = 16,
   parameter int unsigned OP_W     = 5,
   parameter int unsigned MEM_WAIT = 255
) (
   input  logic            clock,
   input  logic            clear,
   input  logic [31:0]     ir,
   input  logic            mem_ready,
   output logic [NREG-1:0] r_out,
   output logic [NREG-1:0] r_in,
   output logic            PCout,
   output logic            PCin,
   output logic            IncPC,
   output logic            MARin,
   output logic            MDRin,
   output logic            MDRout,
   output logic            IRin,
   output logic            Yin,
   output logic            Zlowin,
   output logic            Zhighin,
   output logic            Zlowout,
   output logic            Zhighout,
   output logic            HIin,
   output logic            HIout,
   output logic            LOin,
   output logic            LOout,
   output logic            Cout,
   output logic            Read,
   output logic            Write,
   output logic [OP_W-1:0] alu_op,
   output logic            run,
   output logic            illegal_op,
   output logic            mem_fault
);

   localparam int unsigned cntW = $clog2(MEM_WAIT + 1);

   localparam logic [4:0] opAddi = 5'b01000;
   localparam logic [4:0] opAndi = 5'b01001;
   localparam logic [4:0] opOri  = 5'b01010;
   localparam logic [4:0] opLd   = 5'b01011;
   localparam logic [4:0] opSt   = 5'b01100;
   localparam logic [4:0] opMul  = 5'b01101;
   localparam logic [4:0] opDiv  = 5'b01110;
   localparam logic [4:0] opMfhi = 5'b01111;
   localparam logic [4:0] opMflo = 5'b10000;
   localparam logic [4:0] opHalt = 5'b10010;

   // ALU codes used for address calculation, IncPC and the immediate forms
   localparam logic [4:0] aluAdd = 5'b00011;
   localparam logic [4:0] aluAnd = 5'b00101;
   localparam logic [4:0] aluOr  = 5'b00110;

   typedef enum logic [3:0] {
      sT0, sT1, sT1W, sT2, sT3, sT4, sT5, sT6, sT7, sHalted
   } stepT;

   stepT            state;
   logic [cntW-1:0] waitCnt;
   logic            runQ;
   logic            faultQ;

   logic [4:0] op;
   logic [3:0] ra, rb, rc;
   logic       unusedIr;

   assign op       = ir[31:27];
   assign ra       = ir[26:23];
   assign rb       = ir[22:19];
   assign rc       = ir[18:15];
   assign unusedIr = ^ir[14:0];

   // Instruction class decode
   logic isAluR, isAluI, isLd, isSt, isMulDiv, isMfhi, isMflo, isHalt, isIllegal;
   assign isAluR    = (op <= 5'd7);
   assign isAluI    = (op == opAddi) || (op == opAndi) || (op == opOri);
   assign isLd      = (op == opLd);
   assign isSt      = (op == opSt);
   assign isMulDiv  = (op == opMul) || (op == opDiv);
   assign isMfhi    = (op == opMfhi);
   assign isMflo    = (op == opMflo);
   assign isHalt    = (op == opHalt);
   assign isIllegal = (op > opHalt);

   // Memory wait states and timeout detection
   logic inWait, waitExpire;
   assign inWait     = (state == sT1W) || (state == sT6 && isLd) || (state == sT7 && isSt);
   assign waitExpire = inWait && !mem_ready && (waitCnt == cntW'(MEM_WAIT - 1));

   function automatic logic [NREG-1:0] regSel(input logic [3:0] idx);
      return NREG'(1) << idx;
   endfunction

   function automatic logic [4:0] immAlu(input logic [4:0] code);
      logic [4:0] res;
      case (code)
         opAddi:  res = aluAdd;
         opAndi:  res = aluAnd;
         default: res = aluOr;
      endcase
      return res;
   endfunction

   // Step sequencing, wait counter, run and fault flags
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state   <= sT0;
         waitCnt <= '0;
         runQ    <= 1'b0;
         faultQ  <= 1'b0;
      end else begin
         runQ <= 1'b1;
         if (inWait && !mem_ready) waitCnt <= waitCnt + 1'b1;
         else                      waitCnt <= '0;

         if (waitExpire) begin
            faultQ  <= 1'b1;
            runQ    <= 1'b0;
            waitCnt <= '0;
            state   <= sHalted;
         end else begin
            case (state)
               sT0:  state <= sT1;
               sT1:  state <= sT1W;
               sT1W: if (mem_ready) state <= sT2;
               sT2:  state <= sT3;
               sT3: begin
                  if (isHalt) begin
                     state <= sHalted;
                     runQ  <= 1'b0;
                  end else if (isAluR || isAluI || isLd || isSt || isMulDiv) begin
                     state <= sT4;
                  end else begin
                     state <= sT0;
                  end
               end
               sT4:  state <= sT5;
               sT5:  state <= (isLd || isSt || isMulDiv) ? sT6 : sT0;
               sT6: begin
                  if (isLd) begin
                     if (mem_ready) state <= sT7;
                  end else if (isSt) begin
                     state <= sT7;
                  end else begin
                     state <= sT0;
                  end
               end
               sT7:  if (!isSt || mem_ready) state <= sT0;
               sHalted: begin
                  state <= sHalted;
                  runQ  <= 1'b0;
               end
               default: state <= sT0;
            endcase
         end
      end
   end

   assign run       = runQ;
   assign mem_fault = faultQ;

   // Strobe decode from current step and IR; everything held low while clear is asserted
   always_comb begin
      r_out = '0;  r_in = '0;
      PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
      IRin = 1'b0; Yin = 1'b0; Zlowin = 1'b0; Zhighin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
      HIin = 1'b0; HIout = 1'b0; LOin = 1'b0; LOout = 1'b0; Cout = 1'b0;
      Read = 1'b0; Write = 1'b0; alu_op = '0; illegal_op = 1'b0;
      if (!clear) begin
         case (state)
            sT0: begin
               PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; alu_op = OP_W'(aluAdd);
            end
            sT1: begin
               Zlowout = 1'b1; PCin = 1'b1;
            end
            sT1W: begin
               Read = 1'b1; MDRin = mem_ready;
            end
            sT2: begin
               MDRout = 1'b1; IRin = 1'b1;
            end
            sT3: begin
               if (isAluR || isAluI) begin
                  r_out = regSel(rb); Yin = 1'b1;
               end else if (isLd || isSt) begin
                  // base register R0 means a zero base: nothing drives the bus
                  r_out = (rb == 4'd0) ? '0 : regSel(rb); Yin = 1'b1;
               end else if (isMulDiv) begin
                  r_out = regSel(ra); Yin = 1'b1;
               end else if (isMfhi) begin
                  HIout = 1'b1; r_in = regSel(ra);
               end else if (isMflo) begin
                  LOout = 1'b1; r_in = regSel(ra);
               end else if (isIllegal) begin
                  illegal_op = 1'b1;
               end
            end
            sT4: begin
               if (isAluR) begin
                  r_out = regSel(rc); alu_op = OP_W'(op); Zlowin = 1'b1;
               end else if (isAluI) begin
                  Cout = 1'b1; alu_op = OP_W'(immAlu(op)); Zlowin = 1'b1;
               end else if (isLd || isSt) begin
                  Cout = 1'b1; alu_op = OP_W'(aluAdd); Zlowin = 1'b1;
               end else if (isMulDiv) begin
                  r_out = regSel(rb); alu_op = OP_W'(op); Zlowin = 1'b1; Zhighin = 1'b1;
               end
            end
            sT5: begin
               Zlowout = 1'b1;
               if (isAluR || isAluI)   r_in  = regSel(ra);
               else if (isLd || isSt)  MARin = 1'b1;
               else if (isMulDiv)      LOin  = 1'b1;
            end
            sT6: begin
               if (isLd) begin
                  Read = 1'b1; MDRin = mem_ready;
               end else if (isSt) begin
                  r_out = regSel(ra); MDRin = 1'b1;
               end else if (isMulDiv) begin
                  Zhighout = 1'b1; HIin = 1'b1;
               end
            end
            sT7: begin
               if (isLd) begin
                  MDRout = 1'b1; r_in = regSel(ra);
               end else if (isSt) begin
                  Write = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a step-list reference model builds the expected strobe trace per instruction.
module tb_control_sequencer;

   localparam int unsigned memWait = 4;

   typedef struct packed {
      logic [15:0] rOut;
      logic [15:0] rIn;
      logic pcOut, pcIn, incPc, marIn, mdrIn, mdrOut, irIn, yIn, zLowIn, zHighIn;
      logic zLowOut, zHighOut, hiIn, hiOut, loIn, loOut, cOut;
      logic read, write;
      logic [4:0] aluOp;
      logic illegal, run, fault;
   } outT;

   logic clock = 1'b0;
   logic clear = 1'b1;
   logic [31:0] ir = '0;
   logic mem_ready = 1'b0;
   logic [15:0] r_out, r_in;
   logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zhighin;
   logic Zlowout, Zhighout, HIin, HIout, LOin, LOout, Cout, Read, Write;
   logic [4:0] alu_op;
   logic run, illegal_op, mem_fault;

   int checks = 0;
   int errors = 0;
   outT  expQ[$];
   logic rdyQ[$];
   outT  obsQ[$];
   bit   freshClear = 1'b1;

   always #5 clock = ~clock;

   control_sequencer #(.NREG(16), .OP_W(5), .MEM_WAIT(memWait)) dut (
      .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
      .r_out(r_out), .r_in(r_in),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
      .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout),
      .Zhighout(Zhighout), .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout), .Cout(Cout),
      .Read(Read), .Write(Write), .alu_op(alu_op), .run(run), .illegal_op(illegal_op),
      .mem_fault(mem_fault)
   );

   function automatic outT sample();
      outT o;
      o.rOut = r_out; o.rIn = r_in;
      o.pcOut = PCout; o.pcIn = PCin; o.incPc = IncPC; o.marIn = MARin; o.mdrIn = MDRin;
      o.mdrOut = MDRout; o.irIn = IRin; o.yIn = Yin; o.zLowIn = Zlowin; o.zHighIn = Zhighin;
      o.zLowOut = Zlowout; o.zHighOut = Zhighout; o.hiIn = HIin; o.hiOut = HIout;
      o.loIn = LOin; o.loOut = LOout; o.cOut = Cout; o.read = Read; o.write = Write;
      o.aluOp = alu_op; o.illegal = illegal_op; o.run = run; o.fault = mem_fault;
      return o;
   endfunction

   function automatic logic [15:0] sel(input int r);
      logic [15:0] one;
      one = 16'd1;
      return one << r;
   endfunction

   function automatic outT active();
      outT s;
      s = '0;
      s.run = 1'b1;
      return s;
   endfunction

   function automatic outT t0Step();
      outT s;
      s = active();
      s.pcOut = 1'b1; s.marIn = 1'b1; s.incPc = 1'b1; s.zLowIn = 1'b1; s.aluOp = 5'd3;
      return s;
   endfunction

   // run is still low in the first cycle after clear is released
   function automatic void push(input outT s, input logic rdy);
      outT e;
      e = s;
      if (freshClear) begin
         e.run = 1'b0;
         freshClear = 1'b0;
      end
      expQ.push_back(e);
      rdyQ.push_back(rdy);
   endfunction

   // mem_ready is a don't-care outside wait steps, so it is randomised there
   function automatic void pushStep(input outT s);
      push(s, 1'($urandom_range(0, 1)));
   endfunction

   // lat cycles without mem_ready, then the completing cycle (which loads MDR on a read)
   function automatic void addWait(input outT s, input int lat);
      outT d;
      d = s;
      for (int k = 0; k < lat; k++) push(d, 1'b0);
      if (d.read) d.mdrIn = 1'b1;
      push(d, 1'b1);
   endfunction

   // Reference model: expected per-cycle outputs of one instruction from fetch to its last step
   function automatic void buildInstr(input logic [31:0] instr, input int latF, input int latM,
                                      input int haltCycles);
      logic [4:0] op;
      int ra, rb, rc;
      outT s;
      outT z;
      op = instr[31:27];
      ra = int'(instr[26:23]);
      rb = int'(instr[22:19]);
      rc = int'(instr[18:15]);
      z  = '0;
      expQ.delete();
      rdyQ.delete();
      pushStep(t0Step());
      s = active(); s.zLowOut = 1'b1; s.pcIn = 1'b1; pushStep(s);
      s = active(); s.read = 1'b1; addWait(s, latF);
      s = active(); s.mdrOut = 1'b1; s.irIn = 1'b1; pushStep(s);
      if (op <= 5'd10) begin
         s = active(); s.rOut = sel(rb); s.yIn = 1'b1; pushStep(s);
         s = active(); s.zLowIn = 1'b1;
         if (op <= 5'd7) begin
            s.rOut = sel(rc); s.aluOp = op;
         end else begin
            s.cOut = 1'b1;
            s.aluOp = (op == 5'd8) ? 5'd3 : (op == 5'd9) ? 5'd5 : 5'd6;
         end
         pushStep(s);
         s = active(); s.zLowOut = 1'b1; s.rIn = sel(ra); pushStep(s);
      end else if (op == 5'd11 || op == 5'd12) begin
         s = active(); s.rOut = (rb == 0) ? 16'd0 : sel(rb); s.yIn = 1'b1; pushStep(s);
         s = active(); s.cOut = 1'b1; s.aluOp = 5'd3; s.zLowIn = 1'b1; pushStep(s);
         s = active(); s.zLowOut = 1'b1; s.marIn = 1'b1; pushStep(s);
         if (op == 5'd11) begin
            s = active(); s.read = 1'b1; addWait(s, latM);
            s = active(); s.mdrOut = 1'b1; s.rIn = sel(ra); pushStep(s);
         end else begin
            s = active(); s.rOut = sel(ra); s.mdrIn = 1'b1; pushStep(s);
            s = active(); s.write = 1'b1; addWait(s, latM);
         end
      end else if (op == 5'd13 || op == 5'd14) begin
         s = active(); s.rOut = sel(ra); s.yIn = 1'b1; pushStep(s);
         s = active(); s.rOut = sel(rb); s.aluOp = op; s.zLowIn = 1'b1; s.zHighIn = 1'b1; pushStep(s);
         s = active(); s.zLowOut = 1'b1; s.loIn = 1'b1; pushStep(s);
         s = active(); s.zHighOut = 1'b1; s.hiIn = 1'b1; pushStep(s);
      end else if (op == 5'd15 || op == 5'd16) begin
         s = active();
         if (op == 5'd15) s.hiOut = 1'b1;
         else             s.loOut = 1'b1;
         s.rIn = sel(ra);
         pushStep(s);
      end else if (op == 5'd18) begin
         pushStep(active());
         for (int k = 0; k < haltCycles; k++) pushStep(z);
      end else begin
         s = active(); s.illegal = (op > 5'd18); pushStep(s);
      end
   endfunction

   // Plays the expected mem_ready schedule and records outputs mid-cycle
   task automatic driveTrace(input int maxCycles);
      obsQ.delete();
      for (int i = 0; i < expQ.size() && i < maxCycles; i++) begin
         mem_ready = rdyQ[i];
         @(negedge clock);
         obsQ.push_back(sample());
         @(posedge clock);
         #1;
      end
   endtask

   task automatic doClear();
      clear = 1'b1;
      @(posedge clock);
      #1;
      clear = 1'b0;
      freshClear = 1'b1;
   endtask

   function automatic logic [31:0] mkIr(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [18:0] c);
      return {op, ra, rb, c};
   endfunction

   task automatic test_reset();
      outT o;
      outT e;
      clear = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      o = sample();
      checks++;
      if (o !== outT'(0)) begin
         errors++;
         $display("FAIL reset_outputs: got %h want %h", o, outT'(0));
      end
      clear = 1'b0;
      freshClear = 1'b1;
      #1;
      o = sample();
      e = t0Step();
      e.run = 1'b0;
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL reset_release_t0: got %h want %h", o, e);
      end
   endtask

   task automatic test_add();
      ir = mkIr(5'd3, 4'd3, 4'd1, {4'd2, 15'd0});
      buildInstr(ir, 0, 0, 0);
      driveTrace(1000);
      for (int i = 0; i < obsQ.size(); i++) begin
         checks++;
         if (obsQ[i] !== expQ[i]) begin
            errors++;
            $display("FAIL add cycle %0d: got %h want %h", i, obsQ[i], expQ[i]);
         end
      end
      #3;
      checks++;
      if (PCout !== 1'b1 || MARin !== 1'b1) begin
         errors++;
         $display("FAIL add_next_fetch: got PCout=%b MARin=%b want 1 1", PCout, MARin);
      end
   endtask

   task automatic test_ld();
      ir = mkIr(5'd11, 4'd2, 4'd0, 19'h55);
      buildInstr(ir, int'($urandom_range(0, 3)), 3, 0);
      driveTrace(1000);
      for (int i = 0; i < obsQ.size(); i++) begin
         checks++;
         if (obsQ[i] !== expQ[i]) begin
            errors++;
            $display("FAIL ld cycle %0d: got %h want %h", i, obsQ[i], expQ[i]);
         end
      end
   endtask

   task automatic test_st();
      ir = mkIr(5'd12, 4'd4, 4'd5, 19'd0);
      buildInstr(ir, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 0);
      driveTrace(1000);
      for (int i = 0; i < obsQ.size(); i++) begin
         checks++;
         if (obsQ[i] !== expQ[i]) begin
            errors++;
            $display("FAIL st cycle %0d: got %h want %h", i, obsQ[i], expQ[i]);
         end
      end
   endtask

   task automatic test_illegal();
      for (int n = 0; n < 3; n++) begin
         logic [4:0] op;
         op = (n == 0) ? 5'd31 : 5'($urandom_range(19, 30));
         ir = mkIr(op, 4'($urandom), 4'($urandom), 19'($urandom));
         buildInstr(ir, int'($urandom_range(0, 3)), 0, 0);
         driveTrace(1000);
         for (int i = 0; i < obsQ.size(); i++) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin
               errors++;
               $display("FAIL illegal op=%0d cycle %0d: got %h want %h", op, i, obsQ[i], expQ[i]);
            end
         end
      end
   endtask

   task automatic test_halt();
      ir = mkIr(5'd18, 4'd0, 4'd0, 19'd0);
      buildInstr(ir, int'($urandom_range(0, 3)), 0, 20);
      driveTrace(1000);
      for (int i = 0; i < obsQ.size(); i++) begin
         checks++;
         if (obsQ[i] !== expQ[i]) begin
            errors++;
            $display("FAIL halt cycle %0d: got %h want %h", i, obsQ[i], expQ[i]);
         end
      end
      doClear();
   endtask

   task automatic test_mem_fault();
      outT s;
      outT h;
      expQ.delete();
      rdyQ.delete();
      pushStep(t0Step());
      s = active(); s.zLowOut = 1'b1; s.pcIn = 1'b1; pushStep(s);
      s = active(); s.read = 1'b1;
      for (int k = 0; k < int'(memWait); k++) push(s, 1'b0);
      h = '0; h.fault = 1'b1;
      for (int k = 0; k < 20; k++) pushStep(h);
      driveTrace(1000);
      for (int i = 0; i < obsQ.size(); i++) begin
         checks++;
         if (obsQ[i] !== expQ[i]) begin
            errors++;
            $display("FAIL mem_fault cycle %0d: got %h want %h", i, obsQ[i], expQ[i]);
         end
      end
      doClear();
      checks++;
      if (mem_fault !== 1'b0) begin
         errors++;
         $display("FAIL mem_fault_cleared: got %b want 0", mem_fault);
      end
   endtask

   task automatic test_clear_mid();
      int latF;
      outT o;
      outT e;
      latF = int'($urandom_range(0, 3));
      ir = mkIr(5'd3, 4'd7, 4'd6, {4'd5, 15'd0});
      buildInstr(ir, latF, 0, 0);
      driveTrace(latF + 5);
      for (int i = 0; i < obsQ.size(); i++) begin
         checks++;
         if (obsQ[i] !== expQ[i]) begin
            errors++;
            $display("FAIL clear_mid_pre cycle %0d: got %h want %h", i, obsQ[i], expQ[i]);
         end
      end
      #2;
      clear = 1'b1;
      #1;
      o = sample();
      checks++;
      if (o !== outT'(0)) begin
         errors++;
         $display("FAIL clear_mid_async: got %h want %h", o, outT'(0));
      end
      @(posedge clock);
      #1;
      o = sample();
      checks++;
      if (o !== outT'(0)) begin
         errors++;
         $display("FAIL clear_mid_held: got %h want %h", o, outT'(0));
      end
      clear = 1'b0;
      freshClear = 1'b1;
      #1;
      o = sample();
      e = t0Step();
      e.run = 1'b0;
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL clear_mid_restart: got %h want %h", o, e);
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 30; n++) begin
         logic [4:0] op;
         op = 5'($urandom_range(0, 31));
         if (op == 5'd18) op = 5'd17;
         ir = mkIr(op, 4'($urandom), 4'($urandom), 19'($urandom));
         buildInstr(ir, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
         driveTrace(1000);
         for (int i = 0; i < obsQ.size(); i++) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin
               errors++;
               $display("FAIL b2b n=%0d op=%0d cycle %0d: got %h want %h", n, op, i, obsQ[i], expQ[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_ld();
      test_st();
      test_illegal();
      test_back_to_back();
      test_clear_mid();
      test_add();
      test_halt();
      test_back_to_back();
      test_mem_fault();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, want finish before time limit");
      $fatal(1, "time limit reached");
   end

endmodule
